// File: rtl/vedic_dot_acc.sv
// vedic_dot_acc: accumulates multiplier products into dot-product sums and streams them out through a small FIFO.
module vedic_dot_acc #(
  parameter int PROD_W = 8,
  parameter int ACC_W = 12,
  parameter int MAX_LEN = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_prod_valid,
  input  logic [PROD_W-1:0]             s_prod_data,
  input  logic                          s_prod_last,
  output logic [ACC_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_free,
  output logic                          overflow,
  output logic                          len_err
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int RW = $clog2(ROW_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROW_LEN - 1);
  localparam logic [OW-1:0] DEPTH = OW'(FIFO_DEPTH);

  logic [ACC_W-1:0] acc, sum_next;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] mem_data [FIFO_DEPTH];
  logic             mem_last [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ;
  logic [RW-1:0]    row;
  logic             at_max, push, pop, full, accept;

  // cnt==0 marks the first product, so acc needs no explicit clear on the fly
  assign sum_next = (cnt == '0 ? '0 : acc) + ACC_W'(s_prod_data);
  assign at_max   = cnt == CNT_MAX;
  assign push     = s_prod_valid & (s_prod_last | at_max);
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign full     = occ == DEPTH;
  assign accept   = push & (!full | pop);

  assign m_axis_tvalid = occ != '0;
  assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid & mem_last[rd_ptr];
  assign fifo_free     = DEPTH - occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      row      <= '0;
      overflow <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      if (s_prod_valid) begin
        acc <= push ? '0 : sum_next;
        cnt <= push ? '0 : cnt + CW'(1);
      end
      if (accept) begin
        mem_data[wr_ptr] <= sum_next;
        mem_last[wr_ptr] <= row == ROW_MAX;
        wr_ptr           <= wr_ptr + AW'(1);
        row              <= row == ROW_MAX ? '0 : row + RW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ      <= (accept & !pop) ? occ + OW'(1) : (pop & !accept) ? occ - OW'(1) : occ;
      overflow <= overflow | (push & !accept);
      len_err  <= len_err | (s_prod_valid & at_max & !s_prod_last);
    end
  end
endmodule

// File: tb/tb_vedic_dot_acc.sv
// tb_vedic_dot_acc: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_vedic_dot_acc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_prod_valid = 1'b0;
  logic [7:0]  s_prod_data = '0;
  logic        s_prod_last = 1'b0;
  logic [11:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [2:0]  fifo_free;
  logic        overflow;
  logic        len_err;

  int checks = 0;
  int failures = 0;
  int rowc = 0;
  logic [12:0] exp_q [$];

  vedic_dot_acc dut (
    .clk(clk), .rst_n(rst_n),
    .s_prod_valid(s_prod_valid), .s_prod_data(s_prod_data), .s_prod_last(s_prod_last),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .fifo_free(fifo_free), .overflow(overflow), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A transfer is decided by values that are stable at the negedge before the capturing posedge
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got data %0d with no expected entry", m_axis_tdata);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("out_data", int'(m_axis_tdata), int'(e[11:0]));
        chk("out_last", int'(m_axis_tlast), int'(e[12]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prod(input logic [7:0] d, input logic l);
    s_prod_valid = 1'b1;
    s_prod_data = d;
    s_prod_last = l;
    tick();
    s_prod_valid = 1'b0;
    s_prod_last = 1'b0;
  endtask

  task automatic expect_sum(input int v);
    exp_q.push_back({rowc == 3 ? 1'b1 : 1'b0, 12'(v)});
    rowc = (rowc + 1) % 4;
  endtask

  task automatic drain;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_tlast", int'(m_axis_tlast), 0);
    chk("rst_fifo_free", int'(fifo_free), 4);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_len_err", int'(len_err), 0);
    exp_q.delete();
    rowc = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    do_reset();

    // 3+5+7 = 15, visible for exactly one cycle
    prod(3, 0);
    prod(5, 0);
    chk("t1_tvalid_before", int'(m_axis_tvalid), 0);
    expect_sum(15);
    prod(7, 1);
    chk("t1_tvalid", int'(m_axis_tvalid), 1);
    chk("t1_tdata", int'(m_axis_tdata), 15);
    chk("t1_free_after_push", int'(fifo_free), 3);
    tick();
    chk("t1_tvalid_drop", int'(m_axis_tvalid), 0);
    chk("t1_free_back", int'(fifo_free), 4);

    // Full-length 16x225 = 3600, then 16 ones without last -> forced push of 16
    for (int i = 0; i < 15; i++) prod(225, 0);
    expect_sum(3600);
    prod(225, 1);
    chk("t2_len_err_clean", int'(len_err), 0);
    for (int i = 0; i < 15; i++) prod(1, 0);
    expect_sum(16);
    prod(1, 0);
    chk("t2_len_err_set", int'(len_err), 1);
    drain();

    // Gapped products 8, 9, 10 -> 27 (fourth result, closes row)
    s_prod_valid = 1'b1; s_prod_data = 8; tick();
    s_prod_valid = 1'b0; tick(); tick();
    s_prod_valid = 1'b1; s_prod_data = 9; tick();
    s_prod_valid = 1'b0; tick();
    expect_sum(27);
    prod(10, 1);
    drain();
    for (int i = 1; i <= 8; i++) begin
      expect_sum(i);
      prod(8'(i), 1);
    end
    drain();

    // Full FIFO with a simultaneous pop and push of 10: no drop
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      expect_sum(i);
      prod(8'(i), 1);
    end
    chk("t4_free_full", int'(fifo_free), 0);
    m_axis_tready = 1'b1;
    expect_sum(10);
    prod(10, 1);
    chk("t4_no_overflow", int'(overflow), 0);
    chk("t4_free_still_full", int'(fifo_free), 0);
    drain();

    // Backpressure fill, then drop of 9 into a full FIFO
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_sum(i);
      prod(8'(i), 1);
      chk("t3_free", int'(fifo_free), 4 - i);
    end
    chk("t3_tvalid_held", int'(m_axis_tvalid), 1);
    chk("t3_tdata_held", int'(m_axis_tdata), 1);
    prod(9, 1);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_free_after_drop", int'(fifo_free), 0);
    tick();
    chk("t3_tdata_stable", int'(m_axis_tdata), 1);
    chk("t3_tlast_stable", int'(m_axis_tlast), 0);
    m_axis_tready = 1'b1;
    drain();
    chk("t3_overflow_sticky", int'(overflow), 1);

    // Reset mid-accumulation discards the partial 50+60
    prod(50, 0);
    prod(60, 0);
    do_reset();
    expect_sum(7);
    prod(7, 1);
    chk("t6_tdata", int'(m_axis_tdata), 7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vedic_dot_acc.md
Name: vedic_dot_acc

Overview:
- Downstream stage of the clocked 4x4 Vedic multiplier in the axis_mul datapath.
- Accumulates a stream of 8-bit products into dot-product sums, one sum per matrix-result element.
- Completed sums are buffered in a small FIFO and presented on an AXI-stream master, with tlast marking the end of each output matrix row.
- The product input cannot stall because the multiplier pipeline has no enable. Upstream throttles issue using the fifo_free count.

Parameters:
- PROD_W, 8: product width (multiplier result width).
- ACC_W, 12: accumulator/output width; 16 x 225 = 3600 fits without overflow.
- MAX_LEN, 16: maximum products per dot product.
- FIFO_DEPTH, 4: result FIFO entries; power of 2.
- ROW_LEN, 4: results per matrix row; tlast is asserted on every ROW_LEN-th output.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst_n, input, 1: synchronous active-low reset.
- s_prod_valid, input, 1: s_prod_data is valid this cycle.
- s_prod_data, input, PROD_W: product from the multiplier.
- s_prod_last, input, 1: final product of the current dot product.
- m_axis_tdata, output, ACC_W: completed dot-product sum.
- m_axis_tvalid, output, 1: FIFO non-empty.
- m_axis_tready, input, 1: downstream accepts.
- m_axis_tlast, output, 1: this result closes a matrix row.
- fifo_free, output, clog2(FIFO_DEPTH)+1: count of free FIFO entries.
- overflow, output, 1: sticky; a sum was dropped because the FIFO was full.
- len_err, output, 1: sticky; MAX_LEN products were received without s_prod_last.

Behaviour:
- Reset (rst_n=0 sampled at a posedge):
  - acc=0, cnt=0, FIFO emptied, row counter=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - fifo_free=FIFO_DEPTH, overflow=0, len_err=0.
  - Reset mid-operation discards the partial sum and all buffered results.
- Accumulate, on each s_prod_valid=1:
  - sum_next = (cnt==0 ? 0 : acc) + zero-extended s_prod_data.
  - If s_prod_last=0 and cnt<MAX_LEN-1: acc<=sum_next; cnt<=cnt+1.
  - If s_prod_last=1: push sum_next into the FIFO; acc<=0; cnt<=0.
  - If cnt==MAX_LEN-1 and s_prod_last=0: same as last (push, clear), and set len_err.
  - s_prod_valid=0: acc and cnt hold. Gaps between products are legal.
- Latency: product marked last sampled at edge N; result is visible on m_axis_* after edge N (tvalid=1 from cycle N+1) if the FIFO was empty.
- FIFO: synchronous, show-ahead; m_axis_tdata/tlast are driven from the head entry.
  - Pop when m_axis_tvalid & m_axis_tready.
  - Push with FIFO full and no pop in the same cycle: the sum is dropped, overflow<=1, and the row counter does not advance.
  - Push and pop in the same cycle: always legal, including when full; occupancy is unchanged.
  - fifo_free updates the cycle after each push/pop; fifo_free = FIFO_DEPTH - occupancy.
- AXI-stream rules:
  - tdata/tlast hold stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.
- Row tlast:
  - Row counter increments on each accepted push, wrapping ROW_LEN-1 -> 0.
  - The entry pushed when row counter==ROW_LEN-1 is stored with tlast=1.
- Arithmetic: unsigned; the accumulator cannot wrap within MAX_LEN at default widths. Wider settings must satisfy ACC_W >= PROD_W + clog2(MAX_LEN).
- Stickies: overflow and len_err clear only on reset.

Test Plan:
- Reset, then products 3, 5, 7 (last on 7), tready=1 -> tdata=15, tvalid high for exactly 1 cycle starting the cycle after 7 is sampled; fifo_free returns to 4.
- 16 products of 225 (last on 16th) -> tdata=3600, len_err=0. Then 16 products of 1 with no last -> sum 16 pushed, len_err=1.
- tready=0; four 1-product dot products (values 1, 2, 3, 4) -> fifo_free 4->0, tvalid held with tdata=1.
  - Fifth sum (9) with FIFO full -> dropped, overflow=1.
  - Then tready=1 -> outputs 1, 2, 3, 4 in order, with tlast=1 on the 4th only.
- FIFO full and tready=1 in the cycle a new sum (10) is pushed -> no overflow; 10 appears after the existing entries.
- Products with gaps (valid pattern 1,0,0,1,0,1 carrying 8, 9, 10, last on 10) -> tdata=27. Eight single-product sums -> tlast on outputs 4 and 8 only.
- Two products (50, 60) accumulated, then rst_n=0 for one cycle, then product 7 with last -> tdata=7, tvalid=0 throughout reset, stickies cleared.
